// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the decode stage: control-bundle layout, opcodes, and the
// control_unit / sign_extend helpers.
package id_stage_pipe_pkg;

   localparam int CTRL_W = 16;

   localparam int C_REG_WRITE  = 0;
   localparam int C_MEM_READ   = 1;
   localparam int C_MEM_WRITE  = 2;
   localparam int C_BRANCH     = 3;
   localparam int C_JUMP       = 4;
   localparam int C_ALU_SRC    = 5;
   localparam int C_USE_RS1    = 6;
   localparam int C_USE_RS2    = 7;
   localparam int C_ALUOP_LSB  = 8;
   localparam int C_ALUOP_MSB  = 11;
   localparam int C_MEM_TO_REG = 12;
   localparam int C_IS_JALR    = 13;
   localparam int C_LUI        = 14;
   localparam int C_AUIPC      = 15;

   localparam logic [3:0] ALUOP_ADD = 4'd0;
   localparam logic [3:0] ALUOP_BR  = 4'd1;
   localparam logic [3:0] ALUOP_R   = 4'd2;
   localparam logic [3:0] ALUOP_I   = 4'd3;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_OP_IMM = 7'b0010011,
      OPC_BRANCH = 7'b1100011,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111
   } opcode_e;

   function automatic logic [CTRL_W-1:0] control_unit(input logic [6:0] opcode);
      logic [CTRL_W-1:0] c;
      c = '0;
      case (opcode_e'(opcode))
         OPC_LOAD: begin
            c[C_REG_WRITE] = 1'b1; c[C_MEM_READ] = 1'b1; c[C_ALU_SRC] = 1'b1;
            c[C_USE_RS1] = 1'b1; c[C_MEM_TO_REG] = 1'b1;
         end
         OPC_STORE: begin
            c[C_MEM_WRITE] = 1'b1; c[C_ALU_SRC] = 1'b1;
            c[C_USE_RS1] = 1'b1; c[C_USE_RS2] = 1'b1;
         end
         OPC_OP: begin
            c[C_REG_WRITE] = 1'b1; c[C_USE_RS1] = 1'b1; c[C_USE_RS2] = 1'b1;
            c[C_ALUOP_MSB:C_ALUOP_LSB] = ALUOP_R;
         end
         OPC_OP_IMM: begin
            c[C_REG_WRITE] = 1'b1; c[C_ALU_SRC] = 1'b1; c[C_USE_RS1] = 1'b1;
            c[C_ALUOP_MSB:C_ALUOP_LSB] = ALUOP_I;
         end
         OPC_BRANCH: begin
            c[C_BRANCH] = 1'b1; c[C_USE_RS1] = 1'b1; c[C_USE_RS2] = 1'b1;
            c[C_ALUOP_MSB:C_ALUOP_LSB] = ALUOP_BR;
         end
         OPC_JAL: begin
            c[C_REG_WRITE] = 1'b1; c[C_JUMP] = 1'b1;
         end
         OPC_JALR: begin
            c[C_REG_WRITE] = 1'b1; c[C_JUMP] = 1'b1; c[C_IS_JALR] = 1'b1;
            c[C_ALU_SRC] = 1'b1; c[C_USE_RS1] = 1'b1;
         end
         OPC_LUI: begin
            c[C_REG_WRITE] = 1'b1; c[C_LUI] = 1'b1; c[C_ALU_SRC] = 1'b1;
         end
         OPC_AUIPC: begin
            c[C_REG_WRITE] = 1'b1; c[C_AUIPC] = 1'b1; c[C_ALU_SRC] = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] sign_extend(input logic [31:0] instr);
      logic [31:0] imm;
      imm = 32'd0;
      case (opcode_e'(instr[6:0]))
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'd0};
         OPC_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:    imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/id_stage_pipe_id_ex_reg.sv
// ID/EX pipeline register: flush beats stall, stall beats the load-use bubble.
// Bubbles and empty slots carry an all-zero payload.
module id_ex_reg
   import id_stage_pipe_pkg::*;
#(
   parameter int PW = 8
)(
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_flush,
   input  logic          i_stall,
   input  logic          i_bubble,
   input  logic          i_valid,
   input  logic [PW-1:0] i_data,
   output logic          o_valid,
   output logic [PW-1:0] o_data
);

   logic          valid_d, valid_q;
   logic [PW-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (i_flush) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (i_stall) begin
         valid_d = valid_q;
         data_d  = data_q;
      end else if (i_bubble || !i_valid) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else begin
         valid_d = 1'b1;
         data_d  = i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, decode, load-use detection and the ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data to the register reads.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 32,
   parameter int CTRL_W   = id_stage_pipe_pkg::CTRL_W
)(
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [31:0]       i_id_instr,
   input  logic [WIDTH-1:0]  i_id_pc,
   input  logic [WIDTH-1:0]  i_id_pc_plus4,
   input  logic              i_id_valid,
   input  logic              i_wb_we,
   input  logic [4:0]        i_wb_rd,
   input  logic [WIDTH-1:0]  i_wb_data,
   input  logic              i_ie_flush,
   input  logic              i_ex_stall,
   output logic              o_id_stall,
   output logic              o_ex_valid,
   output logic [CTRL_W-1:0] o_ex_ctrl,
   output logic [WIDTH-1:0]  o_ex_rs1_data,
   output logic [WIDTH-1:0]  o_ex_rs2_data,
   output logic [WIDTH-1:0]  o_ex_imm,
   output logic [WIDTH-1:0]  o_ex_pc,
   output logic [WIDTH-1:0]  o_ex_pc_plus4,
   output logic [4:0]        o_ex_rs1,
   output logic [4:0]        o_ex_rs2,
   output logic [4:0]        o_ex_rd,
   output logic              o_ex_is_load,
   output logic              o_ex_illegal
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int PW    = CTRL_W + 5 * WIDTH + 15 + 2;

   logic [WIDTH-1:0]                    regs_q [NUM_REGS];
   logic [id_stage_pipe_pkg::CTRL_W-1:0] ctrl_full_s;
   logic [CTRL_W-1:0]                   ctrl_s;
   logic [4:0]                          rs1_s, rs2_s, rd_s;
   logic [WIDTH-1:0]                    rs1_data_s, rs2_data_s, imm_s;
   logic signed [31:0]                  imm32_s;
   logic                                use_rs1_s, use_rs2_s, illegal_s, is_load_s, hazard_s;
   logic [PW-1:0]                       payload_d, payload_q;

   assign rs1_s       = i_id_instr[19:15];
   assign rs2_s       = i_id_instr[24:20];
   assign rd_s        = i_id_instr[11:7];
   assign ctrl_full_s = control_unit(i_id_instr[6:0]);
   assign ctrl_s      = CTRL_W'(ctrl_full_s);
   assign imm32_s     = $signed(sign_extend(i_id_instr));
   assign imm_s       = WIDTH'(imm32_s);
   assign use_rs1_s   = ctrl_full_s[C_USE_RS1];
   assign use_rs2_s   = ctrl_full_s[C_USE_RS2];
   assign is_load_s   = ctrl_full_s[C_MEM_READ];

   assign illegal_s = (use_rs1_s && int'(rs1_s) >= NUM_REGS)
                   || (use_rs2_s && int'(rs2_s) >= NUM_REGS)
                   || (ctrl_full_s[C_REG_WRITE] && int'(rd_s) >= NUM_REGS);

   // Register file write port; x0 and out-of-range indices are never written.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (i_wb_we && i_wb_rd != 5'd0 && int'(i_wb_rd) < NUM_REGS) begin
         regs_q[i_wb_rd[IDX_W-1:0]] <= i_wb_data;
      end
   end

   // Register file read ports: x0 and out-of-range indices read as zero.
   always_comb begin
      rs1_data_s = '0;
      rs2_data_s = '0;
      if (rs1_s == 5'd0 || int'(rs1_s) >= NUM_REGS) rs1_data_s = '0;
`ifdef ID_WB_BYPASS_EN
      else if (i_wb_we && i_wb_rd == rs1_s) rs1_data_s = i_wb_data;
`endif
      else rs1_data_s = regs_q[rs1_s[IDX_W-1:0]];
      if (rs2_s == 5'd0 || int'(rs2_s) >= NUM_REGS) rs2_data_s = '0;
`ifdef ID_WB_BYPASS_EN
      else if (i_wb_we && i_wb_rd == rs2_s) rs2_data_s = i_wb_data;
`endif
      else rs2_data_s = regs_q[rs2_s[IDX_W-1:0]];
   end

   assign hazard_s = i_id_valid && o_ex_valid && o_ex_is_load && (o_ex_rd != 5'd0)
                  && ((use_rs1_s && rs1_s == o_ex_rd) || (use_rs2_s && rs2_s == o_ex_rd));

   // Reset gating keeps the stall low while the pipeline is being cleared.
   assign o_id_stall = i_rstn && !i_ie_flush && (i_ex_stall || hazard_s);

   assign payload_d = {ctrl_s, rs1_data_s, rs2_data_s, imm_s, i_id_pc, i_id_pc_plus4,
                       rs1_s, rs2_s, rd_s, is_load_s, illegal_s};

   id_ex_reg #(.PW(PW)) u_id_ex_reg (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_flush  (i_ie_flush),
      .i_stall  (i_ex_stall),
      .i_bubble (hazard_s),
      .i_valid  (i_id_valid),
      .i_data   (payload_d),
      .o_valid  (o_ex_valid),
      .o_data   (payload_q)
   );

   assign {o_ex_ctrl, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_pc, o_ex_pc_plus4,
           o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_is_load, o_ex_illegal} = payload_q;

endmodule
